// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the iterative single-precision multiplier.
package fp_mul_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int          FP_MANT_W  = 23;
  localparam int          FP_PROD_W  = 48;

  // True when the retire width divides the 24-bit significand evenly.
  function automatic logic bpc_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 3) || (bpc == 4) ||
           (bpc == 6) || (bpc == 8) || (bpc == 12) || (bpc == 24);
  endfunction

endpackage

// File: rtl/fp_mul_special.sv
// Special-operand classifier: NaN, infinity and zero/denormal handling.
// Purely combinational; the caller decides when the result is captured.
module fp_mul_special
  import fp_mul_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        is_special,
  output logic [31:0] special_result
);

  logic [7:0] exp_a, exp_b;
  logic       nan_a, nan_b;
  logic       max_a, max_b;
  logic       zero_a, zero_b;
  logic       sign_p;

  assign exp_a  = a[30:23];
  assign exp_b  = b[30:23];
  assign max_a  = (exp_a == FP_EXP_MAX);
  assign max_b  = (exp_b == FP_EXP_MAX);
  assign nan_a  = max_a && (a[22:0] != '0);
  assign nan_b  = max_b && (b[22:0] != '0);
  assign zero_a = (exp_a == 8'h00);
  assign zero_b = (exp_b == 8'h00);
  assign sign_p = a[31] ^ b[31];

  // Priority chain: NaN, inf*0, inf, zero/denormal flush, otherwise normal.
  always_comb begin
    is_special     = 1'b1;
    special_result = FP_QNAN;
    if (nan_a || nan_b) begin
      special_result = FP_QNAN;
    end else if ((max_a && zero_b) || (max_b && zero_a)) begin
      special_result = FP_QNAN;
    end else if (max_a || max_b) begin
      special_result = {sign_p, FP_EXP_MAX, {FP_MANT_W{1'b0}}};
    end else if (zero_a || zero_b) begin
      special_result = {sign_p, 31'h0};
    end else begin
      is_special     = 1'b0;
      special_result = '0;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Iterative IEEE-754 single-precision multiplier (truncating, denormals
// flushed). One 48-bit accumulator retires BITS_PER_CYCLE multiplier bits
// per MULT cycle. Optional macro FP_MUL_SEQ_SAT_EN saturates exponent
// overflow to infinity and underflow to zero instead of wrapping.
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy
);

  localparam int N_ITER = 24 / BITS_PER_CYCLE;
  localparam int CNT_W  = 5;

  if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("fp_mul_seq: BITS_PER_CYCLE must be one of 1,2,3,4,6,8,12,24");
  end

  state_t                 state_q, state_d;
  logic [FP_PROD_W-1:0]   acc_q, acc_d;
  // Multiplicand pre-shifted to the current bit position, so each cycle
  // needs only fixed shifts rather than a barrel shifter on cnt.
  logic [FP_PROD_W-1:0]   mcand_q, mcand_d;
  // Remaining multiplier bits, LSB first; bit 23 is the forced hidden 1.
  logic [23:0]            mplier_q, mplier_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             ea_q, ea_d, eb_q, eb_d;
  logic                   sign_q, sign_d;
  logic [31:0]            out_result_q, out_result_d;

  logic                   is_special;
  logic [31:0]            special_result;

  logic [FP_PROD_W-1:0]   pp [BITS_PER_CYCLE];
  logic [FP_PROD_W-1:0]   step_sum;

  logic                   p_top;
  logic [FP_MANT_W-1:0]   norm_mant;
  logic [9:0]             exp_sum;
  logic [9:0]             exp_unb;
  logic [31:0]            norm_result;
  logic                   norm_unused;

  // The classifier sees the operands on the bus; these are exactly the
  // values registered on the accept edge, so the special result is ready
  // to load on that same edge.
  fp_mul_special u_special (
    .a              (in_a),
    .b              (in_b),
    .is_special     (is_special),
    .special_result (special_result)
  );

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_result = out_result_q;

  // One gated, shifted copy of the multiplicand per retired multiplier bit.
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
    assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  // Sum of this cycle's partial products.
  always_comb begin
    step_sum = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      step_sum = step_sum + pp[j];
    end
  end

  assign p_top     = acc_q[FP_PROD_W-1];
  assign norm_mant = p_top ? acc_q[46:24] : acc_q[45:23];
  assign exp_sum   = {2'b00, ea_q} + {2'b00, eb_q} + {9'd0, p_top};
  assign exp_unb   = exp_sum - 10'(FP_BIAS);
  // Truncated product bits and the exponent headroom bits are dropped.
  assign norm_unused = ^{acc_q[22:0], exp_unb[9:8]};

  // Normalised result; exponent wraps unless saturation is built in.
  always_comb begin
    norm_result = {sign_q, exp_unb[7:0], norm_mant};
`ifdef FP_MUL_SEQ_SAT_EN
    if ($signed(exp_unb) >= 10'sd255) begin
      norm_result = {sign_q, FP_EXP_MAX, {FP_MANT_W{1'b0}}};
    end else if ($signed(exp_unb) <= 10'sd0) begin
      norm_result = {sign_q, 31'h0};
    end
`else
    norm_result = {sign_q, exp_unb[7:0], norm_mant};
`endif
  end

  // Sequencer next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    ea_d         = ea_q;
    eb_d         = eb_q;
    sign_d       = sign_q;
    out_result_d = out_result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ea_d   = in_a[30:23];
          eb_d   = in_b[30:23];
          sign_d = in_a[31] ^ in_b[31];
          if (is_special) begin
            out_result_d = special_result;
            state_d      = DONE;
          end else begin
            acc_d    = '0;
            cnt_d    = '0;
            mcand_d  = {24'h0, 1'b1, in_a[22:0]};
            mplier_d = {1'b1, in_b[22:0]};
            state_d  = MULT;
          end
        end
      end
      MULT: begin
        acc_d    = acc_q + step_sum;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          state_d = NORM;
        end
      end
      NORM: begin
        out_result_d = norm_result;
        state_d      = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      ea_q         <= '0;
      eb_q         <= '0;
      sign_q       <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      ea_q         <= ea_d;
      eb_q         <= eb_d;
      sign_q       <= sign_d;
      out_result_q <= out_result_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed cases, handshake and reset behaviour, and
// random operands against a truncating reference model. Two instances are
// used, retiring 1 and 4 bits per cycle.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_valid4, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, out_valid, busy;
  logic        in_ready4, out_valid4, busy4;
  logic [31:0] out_result, out_result4;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fp_mul_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  fp_mul_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid4), .out_ready(out_ready),
    .out_result(out_result4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: IEEE-754 rules with an integer significand product.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    int          ea, eb, e;
    logic        s;
    longint      p;
    logic [22:0] m;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC00000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    if (p[47]) begin
      m = p[46:24];
      e = ea + eb + 1 - 127;
    end else begin
      m = p[45:23];
      e = ea + eb - 127;
    end
`ifdef FP_MUL_SEQ_SAT_EN
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
`endif
    return {s, e[7:0], m};
  endfunction

  function automatic int exp_latency(input int sel, input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return 1;
    return (sel == 0) ? 26 : 8;
  endfunction

  function automatic logic [31:0] rand_fp(input bit allow_special);
    logic [31:0] v;
    v = $urandom;
    if (allow_special && $urandom_range(0, 7) == 0) begin
      v[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 1) == 1) v[22:0] = '0;
    end else begin
      v[30:23] = 8'($urandom_range(1, 254));
    end
    return v;
  endfunction

  // Present one operand pair for a single accept edge; acc_cyc marks it.
  task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_a = a;
    in_b = b;
    if (sel == 0) in_valid = 1'b1;
    else in_valid4 = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
    acc_cyc   = cyc;
  endtask

  // Latency counts edges from the accept edge inclusive.
  task automatic wait_result(input int sel, output logic [31:0] res, output int lat);
    while ((((sel == 0) ? out_valid : out_valid4) !== 1'b1) && ((cyc - acc_cyc) < 200))
      @(negedge clk);
    lat = cyc - acc_cyc + 1;
    res = (sel == 0) ? out_result : out_result4;
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input int sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat;
    start_op(sel, a, b);
    wait_result(sel, res, lat);
    check(tag, res, exp);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    $display("[TB] %s sel=%0d a=%h b=%h res=%h exp=%h lat=%0d", tag, sel, a, b, res, exp, lat);
    release_op();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, ra, rb, held;
    int          lat;

    rst_n = 1'b0; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed normal and special cases.
    run_op("mul_1p5x2", 0, 32'h3FC00000, 32'h40000000, 32'h40400000, 26);
    run_op("mul_1p5x2_bpc4", 1, 32'h3FC00000, 32'h40000000, 32'h40400000, 8);
    run_op("mul_1p5x1p5", 0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 26);
    run_op("mul_neg2x3", 0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 26);
    run_op("zero_x_inf", 0, 32'h00000000, 32'h7F800000, 32'h7FC00000, 1);
    run_op("inf_x_neg1", 0, 32'h7F800000, 32'hBF800000, 32'hFF800000, 1);
    run_op("negzero_x_1", 0, 32'h80000000, 32'h3F800000, 32'h80000000, 1);
    run_op("nan_x_1", 0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1);
`ifdef FP_MUL_SEQ_SAT_EN
    run_op("overflow", 0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 26);
`else
    run_op("overflow", 0, 32'h7F000000, 32'h7F000000, 32'h3E800000, 26);
`endif

    // Result must hold while the consumer stalls; offers in DONE are refused.
    start_op(0, 32'h3FC00000, 32'h3FC00000);
    wait_result(0, held, lat);
    check("hold_first", held, 32'h40100000);
    in_a = 32'h3F800000; in_b = 32'h3F800000;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("hold_result", out_result, held);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("done_no_accept", 32'(busy), 32'd0);
    $display("[TB] hold a=3fc00000 b=3fc00000 res=%h cycles=10", held);

    // Offer during MULT is not latched.
    start_op(0, 32'h3FC00000, 32'h40000000);
    repeat (5) @(negedge clk);
    in_a = 32'hC0000000; in_b = 32'h40400000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(0, res, lat);
    check("mult_ignore_res", res, 32'h40400000);
    check("mult_ignore_lat", 32'(lat), 32'd26);
    release_op();
    check("mult_ignore_idle", 32'(busy), 32'd0);
    $display("[TB] ignore a=3fc00000 b=40000000 res=%h lat=%0d", res, lat);

    // Asynchronous reset in the middle of MULT.
    start_op(0, 32'h40000000, 32'h40400000);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_result", out_result, 32'h0);
    $display("[TB] reset mid-MULT in_ready=%0d busy=%0d res=%h", in_ready, busy, out_result);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 0, 32'h40000000, 32'h40400000, 32'h40C00000, 26);

    // Random operands against the reference model.
    for (int i = 0; i < 600; i++) begin
      ra = rand_fp(1'b1);
      rb = rand_fp(1'b1);
      run_op("rand1", 0, ra, rb, model(ra, rb), exp_latency(0, ra, rb));
    end
    for (int i = 0; i < 400; i++) begin
      ra = rand_fp(1'b1);
      rb = rand_fp(1'b1);
      run_op("rand4", 1, ra, rb, model(ra, rb), exp_latency(1, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
